reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 94 +++++++++
 tb/tb_reg_file_mp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`default_nettype none
// reg_file_mp: register file with two byte-masked write ports, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero r0 and a per-register pending scoreboard.
// Revision: 1.0
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   R_Addr_A,
    input  logic [ADDR_W-1:0]   R_Addr_B,
    output logic [DATA_W-1:0]   R_Data_A,
    output logic [DATA_W-1:0]   R_Data_B,
    input  logic                W0_En,
    input  logic [ADDR_W-1:0]   W0_Addr,
    input  logic [DATA_W-1:0]   W0_Data,
    input  logic [DATA_W/8-1:0] W0_BE,
    input  logic                W1_En,
    input  logic [ADDR_W-1:0]   W1_Addr,
    input  logic [DATA_W-1:0]   W1_Data,
    input  logic [DATA_W/8-1:0] W1_BE,
    input  logic                Busy_Set,
    input  logic [ADDR_W-1:0]   Busy_Addr,
    output logic                Busy_A,
    output logic                Busy_B
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             pend_q, pend_d;

    // W1 bytes are applied after W0 bytes so W1 wins where both ports enable a byte.
    function automatic logic [DATA_W-1:0] merge(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] old);
        logic [DATA_W-1:0] v;
        v = old;
        for (int b = 0; b < NB; b++) begin
            if (W0_En && (W0_Addr == a) && W0_BE[b]) v[8*b +: 8] = W0_Data[8*b +: 8];
        end
        for (int b = 0; b < NB; b++) begin
            if (W1_En && (W1_Addr == a) && W1_BE[b]) v[8*b +: 8] = W1_Data[8*b +: 8];
        end
        return v;
    endfunction

    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = is_r0(ADDR_W'(i)) ? '0 : merge(ADDR_W'(i), regs_q[i]);
            if ((W0_En && (W0_Addr == ADDR_W'(i))) || (W1_En && (W1_Addr == ADDR_W'(i))))
                pend_d[i] = 1'b0;
            // Set is evaluated last so a same-cycle set beats the write-clear.
            if (Busy_Set && (Busy_Addr == ADDR_W'(i)))
                pend_d[i] = 1'b1;
            if (is_r0(ADDR_W'(i)))
                pend_d[i] = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // regs_d already carries the merged post-edge value, so it doubles as the bypass source.
    always_comb begin
        R_Data_A = '0;
        R_Data_B = '0;
        Busy_A   = 1'b0;
        Busy_B   = 1'b0;
        if (!Reset) begin
            R_Data_A = (BYPASS != 0) ? regs_d[R_Addr_A] : regs_q[R_Addr_A];
            R_Data_B = (BYPASS != 0) ? regs_d[R_Addr_B] : regs_q[R_Addr_B];
            Busy_A   = pend_q[R_Addr_A];
            Busy_B   = pend_q[R_Addr_B];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against an array-based model.
// Revision: 1.0
module tb_reg_file_mp;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  R_Addr_A = '0, R_Addr_B = '0;
    logic [31:0] R_Data_A, R_Data_B;
    logic        W0_En = 1'b0, W1_En = 1'b0;
    logic [4:0]  W0_Addr = '0, W1_Addr = '0;
    logic [31:0] W0_Data = '0, W1_Data = '0;
    logic [3:0]  W0_BE = '0, W1_BE = '0;
    logic        Busy_Set = 1'b0;
    logic [4:0]  Busy_Addr = '0;
    logic        Busy_A, Busy_B;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [32];
    bit          pend [32];

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .W0_En(W0_En), .W0_Addr(W0_Addr), .W0_Data(W0_Data), .W0_BE(W0_BE),
        .W1_En(W1_En), .W1_Addr(W1_Addr), .W1_Data(W1_Data), .W1_BE(W1_BE),
        .Busy_Set(Busy_Set), .Busy_Addr(Busy_Addr),
        .Busy_A(Busy_A), .Busy_B(Busy_B)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value register a will hold after the coming edge: stored bytes overlaid by W0, then W1.
    function automatic logic [31:0] post_val(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = mem[a];
        for (int b = 0; b < 4; b++) begin
            if (W0_En && W0_Addr == a && W0_BE[b]) v[8*b +: 8] = W0_Data[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            if (W1_En && W1_Addr == a && W1_BE[b]) v[8*b +: 8] = W1_Data[8*b +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        return Reset ? 32'h0 : post_val(a);
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return Reset ? 1'b0 : pend[a];
    endfunction

    task automatic check_ports(input string tag);
        chk({tag, "_data_a"}, R_Data_A, exp_data(R_Addr_A));
        chk({tag, "_data_b"}, R_Data_B, exp_data(R_Addr_B));
        chk({tag, "_busy_a"}, 32'(Busy_A), 32'(exp_busy(R_Addr_A)));
        chk({tag, "_busy_b"}, 32'(Busy_B), 32'(exp_busy(R_Addr_B)));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            pend[i] = 1'b0;
        end
    endtask

    // Check pre-edge outputs, advance one clock, then update the model from the held inputs.
    task automatic tick(input string tag);
        logic [31:0] n0, n1;
        #1;
        check_ports(tag);
        @(posedge Clk);
        if (Reset) begin
            model_clear();
        end else begin
            n0 = post_val(W0_Addr);
            n1 = post_val(W1_Addr);
            if (W0_En) mem[W0_Addr] = n0;
            if (W1_En) mem[W1_Addr] = n1;
            if (W0_En) pend[W0_Addr] = 1'b0;
            if (W1_En) pend[W1_Addr] = 1'b0;
            if (Busy_Set && Busy_Addr != 5'd0) pend[Busy_Addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        W0_En = 1'b0; W1_En = 1'b0; Busy_Set = 1'b0;
        W0_BE = '0; W1_BE = '0;
    endtask

    initial begin
        model_clear();
        // Reset held across edges with activity on the write ports.
        W0_En = 1'b1; W0_Addr = 5'd4; W0_Data = 32'hFFFF_FFFF; W0_BE = 4'hF;
        Busy_Set = 1'b1; Busy_Addr = 5'd4; R_Addr_A = 5'd4;
        tick("in_reset");
        tick("in_reset2");
        idle_inputs();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            R_Addr_A = 5'(i); R_Addr_B = 5'(i + 1);
            #1;
            check_ports("post_reset");
        end

        // Partial byte update of an existing word.
        @(posedge Clk); #1;
        W0_En = 1'b1; W0_Addr = 5'd3; W0_Data = 32'h1122_3344; W0_BE = 4'hF;
        R_Addr_A = 5'd3; R_Addr_B = 5'd3;
        tick("be_full");
        W0_Data = 32'hAABB_CCDD; W0_BE = 4'h5;
        tick("be_partial");
        idle_inputs();
        #1;
        chk("be_merge_const", R_Data_A, 32'h11BB_33DD);

        // Same-address collision, with the bypass visible before the edge.
        W0_En = 1'b1; W0_Addr = 5'd7; W0_Data = 32'h0000_00FF; W0_BE = 4'hF;
        W1_En = 1'b1; W1_Addr = 5'd7; W1_Data = 32'hAAAA_0000; W1_BE = 4'hC;
        R_Addr_A = 5'd7;
        #1;
        chk("collide_bypass_const", R_Data_A, 32'hAAAA_00FF);
        tick("collide");
        idle_inputs();
        #1;
        chk("collide_stored_const", R_Data_A, 32'hAAAA_00FF);

        // Register 0 ignores writes, including on the bypass path.
        W0_En = 1'b1; W0_Addr = 5'd0; W0_Data = 32'hDEAD_BEEF; W0_BE = 4'hF;
        W1_En = 1'b1; W1_Addr = 5'd0; W1_Data = 32'hDEAD_BEEF; W1_BE = 4'hF;
        Busy_Set = 1'b1; Busy_Addr = 5'd0; R_Addr_A = 5'd0;
        #1;
        chk("r0_bypass_const", R_Data_A, 32'h0);
        tick("r0_write");
        idle_inputs();
        #1;
        chk("r0_stored_const", R_Data_A, 32'h0);
        chk("r0_busy_const", 32'(Busy_A), 32'h0);

        // Scoreboard: set, set-beats-clear, clear.
        Busy_Set = 1'b1; Busy_Addr = 5'd5; R_Addr_A = 5'd5;
        tick("busy_set");
        Busy_Set = 1'b0;
        #1;
        chk("busy_after_set_const", 32'(Busy_A), 32'h1);
        W1_En = 1'b1; W1_Addr = 5'd5; W1_Data = 32'h5555_5555; W1_BE = 4'h0;
        Busy_Set = 1'b1; Busy_Addr = 5'd5;
        tick("busy_set_clear");
        Busy_Set = 1'b0;
        #1;
        chk("busy_set_wins_const", 32'(Busy_A), 32'h1);
        chk("be_zero_no_change_const", R_Data_A, 32'h0);
        tick("busy_clear");
        idle_inputs();
        #1;
        chk("busy_cleared_const", 32'(Busy_A), 32'h0);

        // Randomized traffic over a small address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            W0_En = 1'($urandom_range(0, 1)); W1_En = 1'($urandom_range(0, 1));
            W0_Addr = 5'($urandom_range(0, 7)); W1_Addr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) W1_Addr = 5'($urandom_range(0, 31));
            W0_Data = $urandom; W1_Data = $urandom;
            W0_BE = 4'($urandom); W1_BE = 4'($urandom);
            Busy_Set = 1'($urandom_range(0, 1)); Busy_Addr = 5'($urandom_range(0, 7));
            R_Addr_A = 5'($urandom_range(0, 7)); R_Addr_B = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) R_Addr_A = W0_Addr;
            if ($urandom_range(0, 3) == 0) R_Addr_B = W1_Addr;
            tick("rand");
        end
        idle_inputs();

        // Asynchronous reset between edges clears data and pending immediately.
        W0_En = 1'b1; W0_Addr = 5'd9; W0_Data = 32'h1234_5678; W0_BE = 4'hF;
        Busy_Set = 1'b1; Busy_Addr = 5'd9; R_Addr_A = 5'd9; R_Addr_B = 5'd9;
        tick("pre_async");
        idle_inputs();
        #1;
        chk("async_pre_data_const", R_Data_A, 32'h1234_5678);
        chk("async_pre_busy_const", 32'(Busy_A), 32'h1);
        #2;
        Reset = 1'b1;
        model_clear();
        #1;
        chk("async_data_const", R_Data_A, 32'h0);
        chk("async_busy_const", 32'(Busy_B), 32'h0);
        W0_En = 1'b1; W0_Addr = 5'd9; W0_Data = 32'hFFFF_FFFF; W0_BE = 4'hF;
        tick("async_hold");
        idle_inputs();
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_ports("async_release");

        // First edge after release accepts writes.
        W1_En = 1'b1; W1_Addr = 5'd9; W1_Data = 32'hCAFE_F00D; W1_BE = 4'hF;
        tick("first_write");
        idle_inputs();
        #1;
        chk("first_write_const", R_Data_A, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
